lbg_split: RTL and testbench



---
 rtl/lbg_pkg.sv | 28 ++
 rtl/lbg_sat_split.sv | 23 ++
 rtl/lbg_split.sv | 146 ++++++++++++++
 tb/tb_lbg_split.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lbg_pkg.sv
// Shared parameters, saturation limits and FSM states for the LBG split stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lbg_pkg;

    localparam int NUM_COEF  = 13;
    localparam int DATA_W    = 14;
    localparam int MAX_CW    = 16;
    localparam int EPS_SHIFT = 5;

    localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SPLIT,
        ST_DONE
    } state_t;

    // Clamp a one-bit-wider result back to DATA_W: overflow shows as the
    // two top bits disagreeing, and the top bit gives the direction.
    function automatic logic signed [DATA_W-1:0] sat(input logic signed [DATA_W:0] v);
        if (v[DATA_W] != v[DATA_W-1])
            return v[DATA_W] ? SAT_MIN : SAT_MAX;
        return v[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/lbg_sat_split.sv
// Perturbs one coefficient into the (1+eps) and (1-eps) pair, saturated.
// Latency: combinational.
// Backpressure: none.
module lbg_sat_split
    import lbg_pkg::*;
(
    input  logic signed [DATA_W-1:0] y,
    output logic signed [DATA_W-1:0] y_hi,
    output logic signed [DATA_W-1:0] y_lo
);

    logic signed [DATA_W-1:0] d;
    logic signed [DATA_W:0]   sum;
    logic signed [DATA_W:0]   dif;

    // Arithmetic shift keeps negative coefficients rounding toward -inf.
    assign d    = y >>> EPS_SHIFT;
    assign sum  = {y[DATA_W-1], y} + {d[DATA_W-1], d};
    assign dif  = {y[DATA_W-1], y} - {d[DATA_W-1], d};
    assign y_hi = sat(sum);
    assign y_lo = sat(dif);

endmodule

// File: rtl/lbg_split.sv
// Captures codeword 0, then doubles the codebook by LBG splitting on request.
// Latency: split of N codewords takes 13N cycles; read port has 1 cycle latency.
// Backpressure: none; requests while busy are dropped, illegal ones set err.
module lbg_split
    import lbg_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     START,
    input  logic                     init_en,
    input  logic [3:0]               init_addr,
    input  logic signed [DATA_W-1:0] init_data,
    output logic                     load_done,
    input  logic                     split_req,
    output logic                     busy,
    output logic                     split_done,
    output logic [4:0]               cw_num,
    output logic                     err,
    input  logic [3:0]               rd_cw,
    input  logic [3:0]               rd_coef,
    output logic signed [DATA_W-1:0] rd_data
);

    state_t state, state_nxt;

    logic signed [DATA_W-1:0] mem [MAX_CW][NUM_COEF];
    logic [3:0] i_cnt;
    logic [3:0] j_cnt;
    logic [3:0] n_cw;
    logic [3:0] lo_idx;
    logic       cw_ok;
    logic       accept;
    logic       last_elem;
    logic       load_wr;
    logic       load_last;
    logic signed [DATA_W-1:0] y_cur;
    logic signed [DATA_W-1:0] y_hi;
    logic signed [DATA_W-1:0] y_lo;

    assign cw_ok     = (cw_num != 5'd0) && (cw_num <= 5'(MAX_CW / 2));
    assign accept    = (state == ST_IDLE) && split_req && cw_ok;
    assign last_elem = (state == ST_SPLIT) && (i_cnt == n_cw - 4'd1)
                       && (j_cnt == 4'(NUM_COEF - 1));
    assign load_wr   = (state == ST_IDLE) && init_en && (init_addr < 4'(NUM_COEF));
    assign load_last = (state == ST_IDLE) && init_en && (init_addr == 4'(NUM_COEF - 1));
    assign lo_idx    = i_cnt + n_cw;
    assign y_cur     = mem[i_cnt][j_cnt];
    assign busy       = (state == ST_SPLIT);
    assign split_done = (state == ST_DONE);

    lbg_sat_split u_sat (
        .y    (y_cur),
        .y_hi (y_hi),
        .y_lo (y_lo)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state: START overrides everything, including a same-edge request.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept)    state_nxt = ST_SPLIT;
            ST_SPLIT: if (last_elem) state_nxt = ST_DONE;
            ST_DONE:                 state_nxt = ST_IDLE;
            default:                 state_nxt = ST_IDLE;
        endcase
        if (START) state_nxt = ST_IDLE;
    end

    // Sweep counters, codeword count, load pulse and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_cnt     <= '0;
            j_cnt     <= '0;
            n_cw      <= '0;
            cw_num    <= '0;
            err       <= 1'b0;
            load_done <= 1'b0;
        end else begin
            load_done <= 1'b0;
            if (START) begin
                i_cnt  <= '0;
                j_cnt  <= '0;
                cw_num <= '0;
                err    <= 1'b0;
            end else begin
                if (load_last) begin
                    cw_num    <= 5'd1;
                    load_done <= 1'b1;
                end
                if (init_en && state == ST_SPLIT)
                    err <= 1'b1;
                if (split_req && state == ST_IDLE && !cw_ok)
                    err <= 1'b1;
                if (accept) begin
                    n_cw  <= cw_num[3:0];
                    i_cnt <= '0;
                    j_cnt <= '0;
                end
                if (state == ST_SPLIT) begin
                    if (j_cnt == 4'(NUM_COEF - 1)) begin
                        j_cnt <= '0;
                        i_cnt <= i_cnt + 4'd1;
                    end else begin
                        j_cnt <= j_cnt + 4'd1;
                    end
                    if (last_elem)
                        cw_num <= {n_cw, 1'b0};
                end
            end
        end
    end

    // Codebook array: initial-centroid writes and split writes. Upper-half
    // destinations are never sources during the same sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < MAX_CW; c++)
                for (int k = 0; k < NUM_COEF; k++)
                    mem[c][k] <= '0;
        end else if (!START) begin
            if (load_wr)
                mem[0][init_addr] <= init_data;
            if (state == ST_SPLIT) begin
                mem[i_cnt][j_cnt]  <= y_hi;
                mem[lo_idx][j_cnt] <= y_lo;
            end
        end
    end

    // Registered read port; rd_cw spans the full array so only rd_coef needs a range check.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_data <= '0;
        else if (rd_coef < 4'(NUM_COEF))
            rd_data <= mem[rd_cw][rd_coef];
        else
            rd_data <= '0;
    end

endmodule

// File: tb/tb_lbg_split.sv
// Directed bench for lbg_split: load, split arithmetic, saturation, chained
// splits, abort by START and asynchronous reset.
module tb_lbg_split;

    logic               clk;
    logic               rst;
    logic               START;
    logic               init_en;
    logic [3:0]         init_addr;
    logic signed [13:0] init_data;
    logic               load_done;
    logic               split_req;
    logic               busy;
    logic               split_done;
    logic [4:0]         cw_num;
    logic               err;
    logic [3:0]         rd_cw;
    logic [3:0]         rd_coef;
    logic signed [13:0] rd_data;

    int checks = 0;
    int errors = 0;

    lbg_split dut (
        .clk        (clk),
        .rst        (rst),
        .START      (START),
        .init_en    (init_en),
        .init_addr  (init_addr),
        .init_data  (init_data),
        .load_done  (load_done),
        .split_req  (split_req),
        .busy       (busy),
        .split_done (split_done),
        .cw_num     (cw_num),
        .err        (err),
        .rd_cw      (rd_cw),
        .rd_coef    (rd_coef),
        .rd_data    (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int addr, input logic signed [13:0] data);
        init_en   = 1'b1;
        init_addr = 4'(addr);
        init_data = data;
        tick();
        init_en   = 1'b0;
    endtask

    task automatic load_cw0(input logic signed [13:0] c0, input logic signed [13:0] c1,
                            input logic signed [13:0] c2, input logic signed [13:0] c3);
        for (int k = 0; k < 13; k++) begin
            case (k)
                0: beat(k, c0);
                1: beat(k, c1);
                2: beat(k, c2);
                3: beat(k, c3);
                default: beat(k, 14'(k * 100));
            endcase
        end
    endtask

    task automatic rd(input int cw, input int coef, output logic signed [13:0] v);
        rd_cw   = 4'(cw);
        rd_coef = 4'(coef);
        tick();
        v = rd_data;
    endtask

    // Issues a request and counts cycles from the sampling edge to split_done.
    task automatic do_split(output int lat, output logic b1);
        split_req = 1'b1;
        tick();
        split_req = 1'b0;
        b1  = busy;
        lat = 1;
        while (split_done !== 1'b1 && lat < 400) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; START = 0; init_en = 0; init_addr = 0; init_data = 0;
        split_req = 0; rd_cw = 0; rd_coef = 0;
        tick(); tick();
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL reset_load_done got %b want 0", load_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (split_done !== 1'b0) begin errors++; $display("FAIL reset_split_done got %b want 0", split_done); end
        checks++; if (cw_num !== 5'd0) begin errors++; $display("FAIL reset_cw_num got %0d want 0", cw_num); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        checks++; if (rd_data !== 14'sd0) begin errors++; $display("FAIL reset_rd_data got %0d want 0", rd_data); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_load();
        logic signed [13:0] v;
        for (int k = 0; k < 12; k++) beat(k, 14'(k * 100));
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL load_done_early got %b want 0", load_done); end
        beat(12, 14'sd1200);
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL load_done_pulse got %b want 1", load_done); end
        checks++; if (cw_num !== 5'd1) begin errors++; $display("FAIL load_cw_num got %0d want 1", cw_num); end
        beat(13, 14'sd777);
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL load_done_one_cycle got %b want 0", load_done); end
        rd(0, 5, v);
        checks++; if (v !== 14'sd500) begin errors++; $display("FAIL read_0_5 got %0d want 500", v); end
        rd(0, 12, v);
        checks++; if (v !== 14'sd1200) begin errors++; $display("FAIL read_0_12 got %0d want 1200", v); end
        rd(0, 13, v);
        checks++; if (v !== 14'sd0) begin errors++; $display("FAIL read_oob_coef got %0d want 0", v); end
    endtask

    task automatic test_split_basic();
        logic signed [13:0] v;
        int lat;
        logic b1;
        load_cw0(14'sd8000, 14'sd320, -14'sd320, -14'sd1);
        do_split(lat, b1);
        checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL split_busy got %b want 1", b1); end
        checks++; if (lat != 14) begin errors++; $display("FAIL split_latency got %0d want 14", lat); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL split_busy_at_done got %b want 0", busy); end
        checks++; if (cw_num !== 5'd2) begin errors++; $display("FAIL split_cw_num got %0d want 2", cw_num); end
        rd(0, 1, v); checks++; if (v !== 14'sd330)  begin errors++; $display("FAIL rd_0_1 got %0d want 330", v); end
        rd(1, 1, v); checks++; if (v !== 14'sd310)  begin errors++; $display("FAIL rd_1_1 got %0d want 310", v); end
        rd(0, 2, v); checks++; if (v !== -14'sd330) begin errors++; $display("FAIL rd_0_2 got %0d want -330", v); end
        rd(1, 2, v); checks++; if (v !== -14'sd310) begin errors++; $display("FAIL rd_1_2 got %0d want -310", v); end
        rd(0, 3, v); checks++; if (v !== -14'sd2)   begin errors++; $display("FAIL rd_0_3 got %0d want -2", v); end
        rd(1, 3, v); checks++; if (v !== 14'sd0)    begin errors++; $display("FAIL rd_1_3 got %0d want 0", v); end
        rd(0, 0, v); checks++; if (v !== 14'sd8191) begin errors++; $display("FAIL rd_sat_hi_0 got %0d want 8191", v); end
        rd(1, 0, v); checks++; if (v !== 14'sd7750) begin errors++; $display("FAIL rd_sat_hi_1 got %0d want 7750", v); end
        rd(1, 5, v); checks++; if (v !== 14'sd485)  begin errors++; $display("FAIL rd_1_5 got %0d want 485", v); end
    endtask

    task automatic test_saturation_low();
        logic signed [13:0] v;
        int lat;
        logic b1;
        load_cw0(-14'sd8192, 14'sd0, 14'sd0, 14'sd0);
        do_split(lat, b1);
        checks++; if (lat != 14) begin errors++; $display("FAIL sat_latency got %0d want 14", lat); end
        rd(0, 0, v); checks++; if (v !== -14'sd8192) begin errors++; $display("FAIL rd_sat_lo_0 got %0d want -8192", v); end
        rd(1, 0, v); checks++; if (v !== -14'sd7936) begin errors++; $display("FAIL rd_sat_lo_1 got %0d want -7936", v); end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic b1;
        int exp_lat [4] = '{14, 27, 53, 105};
        int exp_cw  [4] = '{2, 4, 8, 16};
        load_cw0(14'sd1000, 14'sd320, -14'sd320, -14'sd1);
        for (int s = 0; s < 4; s++) begin
            do_split(lat, b1);
            checks++; if (lat != exp_lat[s]) begin errors++; $display("FAIL b2b_latency_%0d got %0d want %0d", s, lat, exp_lat[s]); end
            checks++; if (cw_num !== 5'(exp_cw[s])) begin errors++; $display("FAIL b2b_cw_num_%0d got %0d want %0d", s, cw_num, exp_cw[s]); end
            tick();
        end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL b2b_err_before got %b want 0", err); end
        split_req = 1'b1;
        tick();
        split_req = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL fifth_split_err got %b want 1", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fifth_split_busy got %b want 0", busy); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fifth_split_busy_later got %b want 0", busy); end
        checks++; if (cw_num !== 5'd16) begin errors++; $display("FAIL fifth_split_cw_num got %0d want 16", cw_num); end
    endtask

    task automatic test_start_abort();
        int lat;
        int seen;
        logic b1;
        START = 1'b1; tick(); START = 1'b0;
        checks++; if (cw_num !== 5'd0) begin errors++; $display("FAIL start_cw_num got %0d want 0", cw_num); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL start_err_clear got %b want 0", err); end
        load_cw0(14'sd1000, 14'sd0, 14'sd0, 14'sd0);
        do_split(lat, b1);
        tick();
        split_req = 1'b1; tick(); split_req = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        beat(12, 14'sd5);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL init_while_busy_err got %b want 1", err); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL init_while_busy_load_done got %b want 0", load_done); end
        for (int c = 0; c < 4; c++) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_pre_busy got %b want 1", busy); end
        START = 1'b1; tick(); START = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        checks++; if (cw_num !== 5'd0) begin errors++; $display("FAIL abort_cw_num got %0d want 0", cw_num); end
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (split_done === 1'b1) seen++;
            tick();
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_split_done got %0d want 0", seen); end
        load_cw0(14'sd1000, 14'sd0, 14'sd0, 14'sd0);
        START = 1'b1; split_req = 1'b1; tick(); START = 1'b0; split_req = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_wins_busy got %b want 0", busy); end
        checks++; if (cw_num !== 5'd0) begin errors++; $display("FAIL start_wins_cw_num got %0d want 0", cw_num); end
    endtask

    task automatic test_rst_mid();
        logic signed [13:0] v;
        int lat;
        logic b1;
        load_cw0(14'sd1000, 14'sd0, 14'sd0, 14'sd0);
        rd_cw = 4'd0; rd_coef = 4'd0;
        split_req = 1'b1; tick(); split_req = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        checks++; if (rd_data !== 14'sd1031) begin errors++; $display("FAIL mid_split_read got %0d want 1031", rd_data); end
        #3 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (cw_num !== 5'd0) begin errors++; $display("FAIL rst_cw_num got %0d want 0", cw_num); end
        checks++; if (rd_data !== 14'sd0) begin errors++; $display("FAIL rst_rd_data got %0d want 0", rd_data); end
        checks++; if (split_done !== 1'b0 || load_done !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL rst_flags got sd=%b ld=%b err=%b want 0", split_done, load_done, err);
        end
        tick();
        rst = 1'b0;
        tick();
        rd(0, 0, v);
        checks++; if (v !== 14'sd0) begin errors++; $display("FAIL rst_read_0_0 got %0d want 0", v); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_split_basic();
        test_saturation_low();
        test_back_to_back();
        test_start_abort();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
